// File: rtl/spi_master_byte_if.sv
// spi_master_byte_if
//   Request/response handshake between on-chip logic and spi_master_byte.
//   Signals:
//     start      request a byte transfer (accepted only while busy=0)
//     tx_data    byte to send, captured when start is accepted
//     hold_cs    captured with start; 1 keeps CS_n low after the byte
//     cs_release pulse; releases a held CS_n while idle
//     busy       transfer, setup or gap in progress
//     done       one-cycle pulse, rx_data valid
//     rx_data    byte received during the last transfer
//   Modports:
//     master  requester side (drives start/tx_data/hold_cs/cs_release)
//     slave   SPI engine side (drives busy/done/rx_data)
interface spi_master_byte_if;
    logic       start;
    logic [7:0] tx_data;
    logic       hold_cs;
    logic       cs_release;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;

    modport master (
        output start, tx_data, hold_cs, cs_release,
        input  busy, done, rx_data
    );

    modport slave (
        input  start, tx_data, hold_cs, cs_release,
        output busy, done, rx_data
    );
endinterface

// File: rtl/spi_master_byte.sv
// spi_master_byte
//   SPI mode 0 (CPOL=0, CPHA=0) master. Shifts one byte per request MSB
//   first on MOSI while capturing the byte returned on MISO. SCLK is built
//   from clk by a half-period counter. CS_n can be held low across bytes.
//   Parameters:
//     HALF_CYC   clk cycles per SCLK half-period (>= 3)
//     SETUP_CYC  clk cycles from CS_n falling to the first SCLK low phase (>= 1)
//     GAP_CYC    minimum clk cycles CS_n stays high after a release (>= 1)
//   Ports:
//     clk   system clock
//     rst   asynchronous active-high reset
//     bus   handshake interface (slave modport)
//     CS_n  chip select, active low
//     SCLK  serial clock, idle low
//     MOSI  serial data out
//     MISO  serial data in, asynchronous (2-flop synchronized here)
module spi_master_byte #(
    parameter int unsigned HALF_CYC  = 3,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned GAP_CYC   = 5
) (
    input  logic                clk,
    input  logic                rst,
    spi_master_byte_if.slave    bus,
    output logic                CS_n,
    output logic                SCLK,
    output logic                MOSI,
    input  logic                MISO
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        HELD,
        SETUP,
        LOW,
        HIGH,
        GAP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         tx_shift_q, tx_shift_d;
    logic [7:0]         rx_shift_q, rx_shift_d;
    logic               hold_q, hold_d;
    logic               cs_n_q, cs_n_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               miso_s1_q, miso_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            hold_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_data_q  <= '0;
            miso_s1_q  <= 1'b0;
            miso_s2_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            hold_q     <= hold_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rx_data_q  <= rx_data_d;
            miso_s1_q  <= MISO;
            miso_s2_q  <= miso_s1_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        hold_d     = hold_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rx_data_d  = rx_data_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tx_shift_d = bus.tx_data;
                    hold_d     = bus.hold_cs;
                    busy_d     = 1'b1;
                    cs_n_d     = 1'b0;
                    cnt_d      = CNT_W'(SETUP_CYC - 1);
                    state_d    = SETUP;
                end
            end

            HELD: begin
                // start has priority over cs_release; CS_n is already low,
                // so the first bit goes out without a setup phase.
                if (bus.start) begin
                    tx_shift_d = bus.tx_data;
                    hold_d     = bus.hold_cs;
                    busy_d     = 1'b1;
                    bit_d      = 3'd7;
                    sclk_d     = 1'b0;
                    mosi_d     = bus.tx_data[7];
                    cnt_d      = CNT_W'(HALF_CYC - 1);
                    state_d    = LOW;
                end else if (bus.cs_release) begin
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_W'(GAP_CYC - 1);
                    state_d = GAP;
                end
            end

            SETUP: begin
                if (cnt_q == '0) begin
                    bit_d   = 3'd7;
                    sclk_d  = 1'b0;
                    mosi_d  = tx_shift_q[7];
                    cnt_d   = CNT_W'(HALF_CYC - 1);
                    state_d = LOW;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            LOW: begin
                if (cnt_q == '0) begin
                    sclk_d     = 1'b1;
                    rx_shift_d = {rx_shift_q[6:0], miso_s2_q};
                    cnt_d      = CNT_W'(HALF_CYC - 1);
                    state_d    = HIGH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            HIGH: begin
                if (cnt_q == '0) begin
                    sclk_d = 1'b0;
                    if (bit_q != 3'd0) begin
                        // Next data bit is launched on the SCLK falling edge.
                        bit_d      = bit_q - 3'd1;
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        mosi_d     = tx_shift_q[6];
                        cnt_d      = CNT_W'(HALF_CYC - 1);
                        state_d    = LOW;
                    end else begin
                        mosi_d    = 1'b0;
                        rx_data_d = rx_shift_q;
                        done_d    = 1'b1;
                        if (hold_q) begin
                            busy_d  = 1'b0;
                            state_d = HELD;
                        end else begin
                            cs_n_d  = 1'b1;
                            cnt_d   = CNT_W'(GAP_CYC - 1);
                            state_d = GAP;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            GAP: begin
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign CS_n        = cs_n_q;
    assign SCLK        = sclk_q;
    assign MOSI        = mosi_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_byte.sv
// tb_spi_master_byte
//   Transaction-level model of the SPI master: each accepted request is
//   described by its accept edge, setup length and data; every output is
//   computed from the edge offset with plain arithmetic and compared on
//   each falling clk edge. Directed loopback, hold, busy-ignore and reset
//   sequences are followed by a randomized phase with random MISO.
`timescale 1ns/1ps
module tb_spi_master_byte;

    localparam int H = 3;
    localparam int S = 1;
    localparam int G = 5;

    logic clk = 1'b0;
    logic rst;
    logic CS_n, SCLK, MOSI, MISO;
    logic loop_mode, miso_r;

    spi_master_byte_if bus ();

    assign MISO = loop_mode ? MOSI : miso_r;

    always #5 clk = ~clk;

    spi_master_byte #(
        .HALF_CYC  (H),
        .SETUP_CYC (S),
        .GAP_CYC   (G)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .CS_n (CS_n),
        .SCLK (SCLK),
        .MOSI (MOSI),
        .MISO (MISO)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         e = 0;              // index of the last rising clk edge
    bit         hist [0:65535];     // MISO as seen at each rising edge
    bit         m_x, m_held, m_gap, m_hold;
    int         m_a, m_s, m_gs, m_done_e;
    logic [7:0] m_tx, m_rx;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_x      = 1'b0;
            m_held   = 1'b0;
            m_gap    = 1'b0;
            m_done_e = -1;
            m_rx     = 8'h00;
        end else begin
            e = e + 1;
            hist[e % 65536] = MISO;
            if (!m_x && !m_gap && bus.start) begin
                m_a    = e;
                m_s    = m_held ? 0 : S;
                m_tx   = bus.tx_data;
                m_hold = bus.hold_cs;
                m_x    = 1'b1;
                m_held = 1'b0;
            end else if (m_held && bus.cs_release) begin
                m_held = 1'b0;
                m_gap  = 1'b1;
                m_gs   = e;
            end else if (m_x && (e - m_a) == m_s + 16 * H) begin
                // Bit b is captured at the end of its low half-period, from
                // the MISO value two edges older (synchronizer depth).
                for (int b = 0; b < 8; b++)
                    m_rx[7 - b] = hist[(m_a + m_s + 2 * b * H + H - 2) % 65536];
                m_done_e = e;
                m_x      = 1'b0;
                if (m_hold) begin
                    m_held = 1'b1;
                end else begin
                    m_gap = 1'b1;
                    m_gs  = e;
                end
            end else if (m_gap && (e - m_gs) == G) begin
                m_gap = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int   k, j, half;
        logic ecs, esclk, emosi, ebusy, edone;
        ecs   = 1'b1;
        esclk = 1'b0;
        emosi = 1'b0;
        ebusy = 1'b0;
        edone = 1'b0;
        if (m_x) begin
            k     = e - m_a;
            ecs   = 1'b0;
            ebusy = 1'b1;
            if (k >= m_s) begin
                j     = k - m_s;
                half  = j / H;
                esclk = ((half % 2) == 1);
                emosi = m_tx[7 - half / 2];
            end
        end else begin
            if (m_held) ecs = 1'b0;
            if (m_gap)  ebusy = 1'b1;
        end
        edone = (m_done_e == e);
        check("cs_n",    32'(CS_n),        32'(ecs));
        check("sclk",    32'(SCLK),        32'(esclk));
        check("mosi",    32'(MOSI),        32'(emosi));
        check("busy",    32'(bus.busy),    32'(ebusy));
        check("done",    32'(bus.done),    32'(edone));
        check("rx_data", 32'(bus.rx_data), 32'(m_rx));
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(bus.busy), 32'(0));
    endtask

    // Called just after a falling edge. lat counts rising edges from the
    // request until done is seen.
    task automatic send(input logic [7:0] d, input bit hold, input bit mess,
                        output int lat, output int rises);
        bit prev, ok;
        bus.start   = 1'b1;
        bus.tx_data = d;
        bus.hold_cs = hold;
        lat   = 0;
        rises = 0;
        prev  = SCLK;
        ok    = 1'b0;
        while (!ok && lat < 400) begin
            @(negedge clk);
            lat++;
            if (mess && lat == 20) begin
                bus.start   = 1'b1;
                bus.tx_data = ~d;
            end else begin
                bus.start = 1'b0;
            end
            if (SCLK && !prev) rises++;
            prev = SCLK;
            if (bus.done) ok = 1'b1;
        end
        check("done_timeout", 32'(ok), 32'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat [4];
        int lat, rises, cnt;
        pat[0] = 8'hA5; pat[1] = 8'h5A; pat[2] = 8'hFF; pat[3] = 8'h00;

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.tx_data    = 8'h00;
        bus.hold_cs    = 1'b0;
        bus.cs_release = 1'b0;
        loop_mode      = 1'b1;
        miso_r         = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs_n",  32'(CS_n),        32'(1));
        check("rst_sclk",  32'(SCLK),        32'(0));
        check("rst_busy",  32'(bus.busy),    32'(0));
        check("rst_rx",    32'(bus.rx_data), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // Loopback: each byte returns unchanged, 8 SCLK rises, fixed latency.
        for (int i = 0; i < 4; i++) begin
            wait_idle();
            send(pat[i], 1'b0, 1'b0, lat, rises);
            check("lb_latency", 32'(lat),         32'(1 + S + 16 * H));
            check("lb_rises",   32'(rises),       32'(8));
            check("lb_rx",      32'(bus.rx_data), 32'(pat[i]));
            if (i == 0) begin
                cnt = 1;
                while (cnt < 50) begin
                    @(negedge clk);
                    if (!bus.busy) break;
                    cnt++;
                end
                check("gap_busy_cycles", 32'(cnt), 32'(G));
            end
        end

        // Request held during the gap: CS_n stays high at least G cycles.
        wait_idle();
        send(8'h3C, 1'b0, 1'b0, lat, rises);
        bus.start   = 1'b1;
        bus.tx_data = 8'hC3;
        cnt = 0;
        while (CS_n && cnt < 50) begin
            @(negedge clk);
            if (CS_n) cnt++;
        end
        check("cs_high_min", 32'(cnt >= G), 32'(1));
        bus.start = 1'b0;
        cnt = 0;
        while (!bus.done && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("gap_next_rx", 32'(bus.rx_data), 32'(8'hC3));

        // Held chip select: back-to-back bytes without setup, then release.
        wait_idle();
        send(8'h11, 1'b1, 1'b0, lat, rises);
        check("hold_first_lat", 32'(lat), 32'(1 + S + 16 * H));
        check("hold_cs_low",    32'(CS_n), 32'(0));
        check("hold_not_busy",  32'(bus.busy), 32'(0));
        send(8'h22, 1'b1, 1'b0, lat, rises);
        check("hold_second_lat", 32'(lat), 32'(1 + 16 * H));
        check("hold_second_rx",  32'(bus.rx_data), 32'(8'h22));
        bus.cs_release = 1'b1;
        send(8'h44, 1'b1, 1'b0, lat, rises);
        bus.cs_release = 1'b0;
        check("start_beats_release", 32'(bus.rx_data), 32'(8'h44));
        check("start_beats_rel_lat", 32'(lat), 32'(1 + 16 * H));
        @(negedge clk);
        check("still_held", 32'(CS_n), 32'(0));
        bus.cs_release = 1'b1;
        @(negedge clk);
        bus.cs_release = 1'b0;
        check("release_cs_n", 32'(CS_n), 32'(1));
        cnt = 1;
        while (cnt < 50) begin
            @(negedge clk);
            if (!bus.busy) break;
            cnt++;
        end
        check("release_gap", 32'(cnt), 32'(G));

        // start and new tx_data during a transfer are ignored.
        wait_idle();
        send(8'h5C, 1'b0, 1'b1, lat, rises);
        check("busy_ignore_rx",  32'(bus.rx_data), 32'(8'h5C));
        check("busy_ignore_lat", 32'(lat), 32'(1 + S + 16 * H));

        // Asynchronous reset during bit 4, then a normal transfer.
        wait_idle();
        bus.start   = 1'b1;
        bus.tx_data = 8'h96;
        bus.hold_cs = 1'b0;
        for (int n = 0; n < 27; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check("arst_cs_n", 32'(CS_n),     32'(1));
        check("arst_sclk", 32'(SCLK),     32'(0));
        check("arst_busy", 32'(bus.busy), 32'(0));
        check("arst_mosi", 32'(MOSI),     32'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(8'h69, 1'b0, 1'b0, lat, rises);
        check("post_rst_rx",  32'(bus.rx_data), 32'(8'h69));
        check("post_rst_lat", 32'(lat), 32'(1 + S + 16 * H));

        // Randomized phase: random requests, releases and MISO data.
        wait_idle();
        loop_mode = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            bus.start      = ($urandom_range(0, 7) == 0);
            bus.tx_data    = 8'($urandom);
            bus.hold_cs    = 1'($urandom_range(0, 1));
            bus.cs_release = ($urandom_range(0, 15) == 0);
            miso_r         = 1'($urandom_range(0, 1));
        end
        bus.start      = 1'b0;
        bus.cs_release = 1'b1;
        repeat (120) @(negedge clk);
        bus.cs_release = 1'b0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
